riscv_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline. It keeps its own shadow pipeline of destination and source register tags for the EX, MEM and WB stages. From these it produces:
- EX-stage forwarding selects for rs1/rs2;
- a load-use stall with bubble insertion;
- a branch flush;
- a full freeze while data memory is busy.

It sits beside the pipeline registers in the pipeline top and drives their hold/flush controls and the ALU operand muxes.

---
 rtl/riscv_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - hazard/forwarding controller with shadow EX/MEM/WB tags
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module riscv_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  stall_if,
  output logic                  stall_id_ex,
  output logic                  freeze,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel,
  output logic [CNT_W-1:0]      perf_loaduse_cnt,
  output logic [CNT_W-1:0]      perf_freeze_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
);

  typedef enum logic [1:0] {
    MODE_ADVANCE,
    MODE_LOAD_USE,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_t;

  logic                  ex_valid, ex_regwrite, ex_memread, ex_rs1_used, ex_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;
  logic                  mem_valid, mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid, wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic  load_use;
  logic  mem_wr_ok, wb_wr_ok;
  mode_t mode;

  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd)));

  assign mem_wr_ok = mem_valid && mem_regwrite && (mem_rd != '0);
  assign wb_wr_ok  = wb_valid && wb_regwrite && (wb_rd != '0);

  always_comb begin
    mode = MODE_ADVANCE;
    if (mem_busy)          mode = MODE_FREEZE;
    else if (branch_taken) mode = MODE_FLUSH;
    else if (load_use)     mode = MODE_LOAD_USE;
  end

  always_comb begin
    stall_if    = 1'b0;
    stall_id_ex = 1'b0;
    freeze      = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      case (mode)
        MODE_FREEZE: begin
          freeze      = 1'b1;
          stall_if    = 1'b1;
          stall_id_ex = 1'b1;
        end
        MODE_FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        MODE_LOAD_USE: begin
          stall_if    = 1'b1;
          flush_id_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // MEM is the younger producer, so it wins over WB
  always_comb begin
    fwd_rs1_sel = 2'd0;
    fwd_rs2_sel = 2'd0;
    if (!rst && ex_valid) begin
      if (ex_rs1_used) begin
        if (mem_wr_ok && (mem_rd == ex_rs1))     fwd_rs1_sel = 2'd1;
        else if (wb_wr_ok && (wb_rd == ex_rs1))  fwd_rs1_sel = 2'd2;
      end
      if (ex_rs2_used) begin
        if (mem_wr_ok && (mem_rd == ex_rs2))     fwd_rs2_sel = 2'd1;
        else if (wb_wr_ok && (wb_rd == ex_rs2))  fwd_rs2_sel = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rs1_used  <= 1'b0;
      ex_rs2_used  <= 1'b0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
    end else if (mode != MODE_FREEZE) begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      if (mode == MODE_ADVANCE) begin
        ex_valid    <= id_valid;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_rs1_used <= id_rs1_used;
        ex_rs2_used <= id_rs2_used;
        ex_rd       <= id_rd_addr;
        ex_rs1      <= id_rs1_addr;
        ex_rs2      <= id_rs2_addr;
      end else begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] loaduse_cnt, freeze_cnt, flush_cnt;

  // Counters saturate at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      loaduse_cnt <= '0;
      freeze_cnt  <= '0;
      flush_cnt   <= '0;
    end else begin
      if (mode == MODE_LOAD_USE && loaduse_cnt != '1) loaduse_cnt <= loaduse_cnt + CNT_W'(1);
      if (mode == MODE_FREEZE && freeze_cnt != '1)    freeze_cnt  <= freeze_cnt + CNT_W'(1);
      if (mode == MODE_FLUSH && flush_cnt != '1)      flush_cnt   <= flush_cnt + CNT_W'(1);
    end
  end

  assign perf_loaduse_cnt = loaduse_cnt;
  assign perf_freeze_cnt  = freeze_cnt;
  assign perf_flush_cnt   = flush_cnt;
`else
  assign perf_loaduse_cnt = '0;
  assign perf_freeze_cnt  = '0;
  assign perf_flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb/tb_riscv_hazard_ctrl.sv - directed table plus random reference-model bench for riscv_hazard_ctrl
module tb_riscv_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_rs1_used, id_rs2_used, id_regwrite, id_memread;
  logic       branch_taken, mem_busy;
  logic       stall_if, stall_id_ex, freeze, flush_if_id, flush_id_ex;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] perf_loaduse_cnt, perf_freeze_cnt, perf_flush_cnt;

  riscv_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id_ex(stall_id_ex), .freeze(freeze),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .perf_loaduse_cnt(perf_loaduse_cnt), .perf_freeze_cnt(perf_freeze_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model: stage 0 = EX, 1 = MEM, 2 = WB ----------------
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit [4:0] rs1, rs2;
    bit       u1, u2;
  } ent_t;

  ent_t pipe[3];
  int   c_lu, c_fr, c_fl;

  function automatic int m_mode();
    bit lu;
    lu = pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && id_valid &&
         ((id_rs1_used && id_rs1_addr == pipe[0].rd) || (id_rs2_used && id_rs2_addr == pipe[0].rd));
    if (mem_busy)     return 3;
    if (branch_taken) return 2;
    if (lu)           return 1;
    return 0;
  endfunction

  function automatic bit [1:0] m_fwd(bit [4:0] src, bit used);
    if (!pipe[0].v || !used) return 2'd0;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src) return 2'(k);
    return 2'd0;
  endfunction

  function automatic bit [8:0] m_expect();
    int md;
    bit [4:0] h;
    if (rst) return 9'd0;
    md = m_mode();
    case (md)
      3:       h = 5'b11100;
      2:       h = 5'b00011;
      1:       h = 5'b10001;
      default: h = 5'b00000;
    endcase
    return {h, m_fwd(pipe[0].rs1, pipe[0].u1), m_fwd(pipe[0].rs2, pipe[0].u2)};
  endfunction

  function automatic int m_cnt(int c);
`ifdef HAZARD_PERF_CNT_EN
    return (c > SAT) ? SAT : c;
`else
    return 0 * c;
`endif
  endfunction

  function automatic void m_step();
    int md;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      c_lu = 0; c_fr = 0; c_fl = 0;
      return;
    end
    md = m_mode();
    if (md == 3) begin
      c_fr++;
      return;
    end
    if (md == 2) c_fl++;
    if (md == 1) c_lu++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (md == 0)
      pipe[0] = '{id_valid, id_rd_addr, id_regwrite, id_memread,
                  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used};
    else
      pipe[0].v = 1'b0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_cycle(input string nm, input bit use_tbl, input bit [8:0] tbl_exp);
    bit [8:0] act;
    @(negedge clk);
    act = {stall_if, stall_id_ex, freeze, flush_if_id, flush_id_ex, fwd_rs1_sel, fwd_rs2_sel};
    chk(nm, int'(act), int'(use_tbl ? tbl_exp : m_expect()));
    chk({nm, " counters"}, int'({perf_loaduse_cnt, perf_freeze_cnt, perf_flush_cnt}),
        (m_cnt(c_lu) << (2 * CW)) | (m_cnt(c_fr) << CW) | m_cnt(c_fl));
    @(posedge clk);
    m_step();
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit       r, idv;
    bit [4:0] rs1, rs2;
    bit       u1, u2;
    bit [4:0] rd;
    bit       rw, mr, br, busy;
    bit [8:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input bit r, input bit idv, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit u1, input bit u2, input bit [4:0] rd, input bit rw,
                      input bit mr, input bit br, input bit busy, input bit [8:0] exp);
    vq.push_back('{r, idv, rs1, rs2, u1, u2, rd, rw, mr, br, busy, exp});
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; id_valid = v.idv; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_rs1_used = v.u1; id_rs2_used = v.u2; id_rd_addr = v.rd;
    id_regwrite = v.rw; id_memread = v.mr; branch_taken = v.br; mem_busy = v.busy;
  endtask

  vec_t idle, frz;

  initial begin
    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0};
    frz  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b11100_00_00};
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    c_lu = 0; c_fr = 0; c_fl = 0;

    // reset with busy and branch asserted
    addv(1, 1, 5, 5, 1, 1, 5, 1, 1, 1, 1, 9'd0);
    addv(1, 1, 5, 5, 1, 1, 5, 1, 1, 1, 1, 9'd0);
    // EX/MEM forwarding
    addv(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 9'd0);
    addv(0, 1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 9'd0);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b00000_01_00);
    // MEM/WB forwarding with one unrelated instruction between
    addv(0, 1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 9'd0);
    addv(0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 9'd0);
    addv(0, 1, 8, 0, 1, 0, 10, 1, 0, 0, 0, 9'd0);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b00000_10_00);
    // write to x0 never forwards
    addv(0, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 9'd0);
    addv(0, 1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 9'd0);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
    // load-use: one stall cycle, then the consumer sees the load in WB
    addv(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 9'd0);
    addv(0, 1, 1, 7, 1, 1, 12, 1, 0, 0, 0, 9'b10001_00_00);
    addv(0, 1, 1, 7, 1, 1, 12, 1, 0, 0, 0, 9'd0);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b00000_00_10);
    // unused rs2 matching the load does not stall
    addv(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 9'd0);
    addv(0, 1, 1, 7, 1, 0, 13, 1, 0, 0, 0, 9'd0);
    // branch wins over load-use
    addv(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 9'd0);
    addv(0, 1, 7, 2, 1, 1, 14, 1, 0, 1, 0, 9'b00011_00_00);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
    // freeze three cycles with branch pending, then the flush lands
    addv(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 9'd0);
    addv(0, 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 9'd0);
    addv(0, 1, 1, 2, 1, 1, 15, 1, 0, 1, 1, 9'b11100_01_01);
    addv(0, 1, 1, 2, 1, 1, 15, 1, 0, 1, 1, 9'b11100_01_01);
    addv(0, 1, 1, 2, 1, 1, 15, 1, 0, 1, 1, 9'b11100_01_01);
    addv(0, 1, 1, 2, 1, 1, 15, 1, 0, 1, 0, 9'b00011_01_01);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);

    drive(vq[0]);
    #1;
    foreach (vq[i]) begin
      drive(vq[i]);
      run_cycle($sformatf("vec%0d", i), 1'b1, vq[i].exp);
    end

    // counter saturation under a long freeze
    for (int i = 0; i < 20; i++) begin
      drive(frz);
      run_cycle($sformatf("sat%0d", i), 1'b1, frz.exp);
    end
    drive(idle);
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    chk("freeze_sat", int'(perf_freeze_cnt), SAT);
`else
    chk("freeze_sat", int'(perf_freeze_cnt), 0);
`endif
    run_cycle("post_sat", 1'b1, 9'd0);

    // reset asserted mid-freeze discards everything
    drive(frz);
    run_cycle("pre_rst_freeze", 1'b1, frz.exp);
    drive(frz);
    rst = 1'b1;
    run_cycle("rst_in_freeze", 1'b1, 9'd0);
    drive(idle);
    run_cycle("after_rst", 1'b1, 9'd0);

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_valid     = ($urandom_range(0, 4) != 0);
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      id_rd_addr   = 5'($urandom_range(0, 3));
      id_rs1_used  = 1'($urandom);
      id_rs2_used  = 1'($urandom);
      id_regwrite  = ($urandom_range(0, 3) != 0);
      id_memread   = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      mem_busy     = ($urandom_range(0, 5) == 0);
      run_cycle($sformatf("rand%0d", i), 1'b0, 9'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
